// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the default datapath width.
package mdu_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [1:0] MDU_MULT_U = 2'b00;
   localparam logic [1:0] MDU_DIV_U  = 2'b01;
   localparam logic [1:0] MDU_MULT_S = 2'b10;
   localparam logic [1:0] MDU_DIV_S  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIXUP,
      FINISH
   } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between pipeline control and the multiply/divide unit.
// master = pipeline control side, slave = the unit itself.
interface mul_div_unit_if #(parameter int WIDTH = 32);

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, wr_hi, wr_lo, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, wr_hi, wr_lo, wdata,
      output busy, done, div_by_zero, hi, lo
   );

endinterface

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the shared accumulator: shift-add for
// multiply, restoring shift-subtract for divide.
module mdu_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   // Multiply keeps the carry of the upper-half add so the right shift loses nothing;
   // divide uses the borrow bit of the trial subtraction as its sign.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
      trial    = acc[2*WIDTH-1:WIDTH-1];
      diff     = trial - {1'b0, operand};
      acc_next = '0;
      if (is_div) begin
         if (!diff[WIDTH])
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else if (acc[0]) begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end else begin
         acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit producing HI/LO, one bit per clock.
// Define MDU_SIGNED_EN to build signed op support (op[1]) and the FIXUP state.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input logic         clk,
   input logic         reset_n,
   mul_div_unit_if.slave mdu
);

`ifdef MDU_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   mdu_state_e         state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_q, b_q, opnd;
   logic [2*WIDTH-1:0] acc, acc_next, fin_acc, prod;
   logic               is_div, signed_q, neg_res, neg_rem, dbz;
   logic [WIDTH-1:0]   a_abs, b_abs, quot, rem, res_hi, res_lo;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               last_iter, load_result, sw_write;

   mdu_iter_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div),
      .acc      (acc),
      .operand  (opnd),
      .acc_next (acc_next)
   );

   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
   assign sw_write  = (state == IDLE) && !mdu.start && (mdu.wr_hi || mdu.wr_lo);

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Result is committed on the edge into FINISH so HI/LO change together with done.
   always_comb begin
      state_next  = state;
      load_result = 1'b0;
      case (state)
         IDLE:   if (mdu.start) state_next = PREP;
         PREP:   state_next = ITER;
         ITER: begin
            if (last_iter) begin
               if (SIGNED_EN && signed_q) begin
                  state_next = FIXUP;
               end else begin
                  state_next  = FINISH;
                  load_result = 1'b1;
               end
            end
         end
         FIXUP: begin
            state_next  = FINISH;
            load_result = 1'b1;
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign mdu.busy        = (state == PREP) || (state == ITER) || (state == FIXUP);
   assign mdu.done        = (state == FINISH);
   assign mdu.div_by_zero = (state == FINISH) && dbz;
   assign mdu.hi          = hi_q;
   assign mdu.lo          = lo_q;

   // Sign fix-up is harmless on unsigned ops because both negate flags stay clear.
   always_comb begin
      a_abs   = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
      b_abs   = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
      fin_acc = (state == FIXUP) ? acc : acc_next;
      prod    = neg_res ? -fin_acc : fin_acc;
      quot    = neg_res ? -fin_acc[WIDTH-1:0] : fin_acc[WIDTH-1:0];
      rem     = neg_rem ? -fin_acc[2*WIDTH-1:WIDTH] : fin_acc[2*WIDTH-1:WIDTH];
      res_hi  = prod[2*WIDTH-1:WIDTH];
      res_lo  = prod[WIDTH-1:0];
      if (is_div) begin
         res_hi = dbz ? a_q : rem;
         res_lo = dbz ? '1  : quot;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_q      <= '0;
         b_q      <= '0;
         opnd     <= '0;
         acc      <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         signed_q <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         dbz      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mdu.start) begin
                  a_q      <= mdu.a;
                  b_q      <= mdu.b;
                  is_div   <= mdu.op[0];
                  signed_q <= SIGNED_EN & mdu.op[1];
               end
            end
            PREP: begin
               cnt     <= '0;
               neg_res <= signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               neg_rem <= signed_q & a_q[WIDTH-1];
               dbz     <= is_div && (b_q == '0);
               if (is_div) begin
                  acc  <= {{WIDTH{1'b0}}, a_abs};
                  opnd <= b_abs;
               end else begin
                  acc  <= {{WIDTH{1'b0}}, b_abs};
                  opnd <= a_abs;
               end
            end
            ITER: begin
               acc <= acc_next;
               cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (load_result) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end else if (sw_write) begin
         if (mdu.wr_hi) hi_q <= mdu.wdata;
         if (mdu.wr_lo) lo_q <= mdu.wdata;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops push expected HI/LO/latency,
// a monitor pops and compares on every done pulse.
module tb_mul_div_unit;
   import mdu_pkg::*;

   localparam int W     = 32;
   localparam int LAT_U = 35;
`ifdef MDU_SIGNED_EN
   localparam int LAT_S = 36;
`else
   localparam int LAT_S = 35;
`endif

   typedef struct {
      string          name;
      logic [W-1:0]   hi;
      logic [W-1:0]   lo;
      logic           dbz;
      int             lat;
      int             start_cyc;
   } exp_t;

   exp_t sb[$];
   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   cyc     = 0;
   int   errors  = 0;
   int   checks  = 0;

   mul_div_unit_if #(.WIDTH(W)) bus ();

   mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .mdu     (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic waitDone(input string name);
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
         if (bus.done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput({name, "_done_seen"}, 64'(seen), 64'd1);
   endtask

   task automatic applyStimulus(input string name, input logic [1:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] ehi, input logic [W-1:0] elo,
                                input logic edbz, input int elat);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      e = '{name: name, hi: ehi, lo: elo, dbz: edbz, lat: elat, start_cyc: cyc};
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = ~op;
      bus.a     = ~a;
      bus.b     = ~b;
      waitDone(name);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.div_by_zero) checkOutput("dbz_only_with_done", 64'(bus.done), 64'd1);
         if (bus.done) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
               e = sb.pop_front();
               checkOutput({e.name, "_hi"},   64'(bus.hi), 64'(e.hi));
               checkOutput({e.name, "_lo"},   64'(bus.lo), 64'(e.lo));
               checkOutput({e.name, "_dbz"},  64'(bus.div_by_zero), 64'(e.dbz));
               checkOutput({e.name, "_busy"}, 64'(bus.busy), 64'd0);
               checkOutput({e.name, "_lat"},  64'(cyc - e.start_cyc + 1), 64'(e.lat));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish, got hang, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bus.start = 1'b0;
      bus.op    = MDU_MULT_U;
      bus.a     = '0;
      bus.b     = '0;
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      bus.wdata = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_hi",   64'(bus.hi), 64'd0);
      checkOutput("rst_lo",   64'(bus.lo), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_done", 64'(bus.done), 64'd0);
      checkOutput("rst_dbz",  64'(bus.div_by_zero), 64'd0);
      reset_n = 1'b1;

      // Preload LO so the mid-op reset has something to clear.
      @(negedge clk);
      bus.wr_lo = 1'b1;
      bus.wdata = 32'h55;
      @(negedge clk);
      bus.wr_lo = 1'b0;
      checkOutput("idle_wr_lo_55", 64'(bus.lo), 64'h55);

      // Mid-op reset: start counts as cycle 1, reset lands at cycle 10, no done expected.
      bus.start = 1'b1;
      bus.op    = MDU_MULT_U;
      bus.a     = 32'd5;
      bus.b     = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("midop_busy_before_reset", 64'(bus.busy), 64'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checkOutput("midop_rst_hi",   64'(bus.hi), 64'd0);
      checkOutput("midop_rst_lo",   64'(bus.lo), 64'd0);
      checkOutput("midop_rst_busy", 64'(bus.busy), 64'd0);
      repeat (40) @(negedge clk);

      applyStimulus("multu_5x7",   MDU_MULT_U, 32'd5, 32'd7, 32'h0, 32'd35, 1'b0, LAT_U);
      applyStimulus("multu_max",   MDU_MULT_U, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001, 1'b0, LAT_U);
      applyStimulus("divu_100_7",  MDU_DIV_U, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT_U);
      applyStimulus("divu_9_0",    MDU_DIV_U, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1, LAT_U);

`ifdef MDU_SIGNED_EN
      applyStimulus("mult_m3_4",   MDU_MULT_S, 32'hFFFFFFFD, 32'd4,
                    32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, LAT_S);
      applyStimulus("div_m7_2",    MDU_DIV_S, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT_S);
      applyStimulus("div_ovf",     MDU_DIV_S, 32'h80000000, 32'hFFFFFFFF,
                    32'h0, 32'h80000000, 1'b0, LAT_S);
      applyStimulus("div_m5_0",    MDU_DIV_S, 32'hFFFFFFFB, 32'd0,
                    32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, LAT_S);
`else
      applyStimulus("mult_m3_4",   MDU_MULT_S, 32'hFFFFFFFD, 32'd4,
                    32'h00000003, 32'hFFFFFFF4, 1'b0, LAT_S);
      applyStimulus("div_m7_2",    MDU_DIV_S, 32'hFFFFFFF9, 32'd2,
                    32'h00000001, 32'h7FFFFFFC, 1'b0, LAT_S);
      applyStimulus("div_ovf",     MDU_DIV_S, 32'h80000000, 32'hFFFFFFFF,
                    32'h80000000, 32'h0, 1'b0, LAT_S);
      applyStimulus("div_m5_0",    MDU_DIV_S, 32'hFFFFFFFB, 32'd0,
                    32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, LAT_S);
`endif

      // start held high through busy, operands changed after acceptance: one op only.
      begin
         exp_t e;
         @(negedge clk);
         bus.start = 1'b1;
         bus.op    = MDU_MULT_U;
         bus.a     = 32'd3;
         bus.b     = 32'd5;
         e = '{name: "held_start", hi: 32'h0, lo: 32'd15, dbz: 1'b0, lat: LAT_U, start_cyc: cyc};
         sb.push_back(e);
         @(negedge clk);
         bus.a = 32'd9;
         bus.b = 32'd9;
         waitDone("held_start");
         bus.start = 1'b0;
         repeat (3) @(negedge clk);
         checkOutput("held_start_idle_busy", 64'(bus.busy), 64'd0);
      end

      // wr_lo while busy must be ignored; HI/LO hold during the op.
      begin
         exp_t e;
         @(negedge clk);
         bus.start = 1'b1;
         bus.op    = MDU_DIV_U;
         bus.a     = 32'd50;
         bus.b     = 32'd5;
         e = '{name: "divu_50_5", hi: 32'h0, lo: 32'd10, dbz: 1'b0, lat: LAT_U, start_cyc: cyc};
         sb.push_back(e);
         @(negedge clk);
         bus.start = 1'b0;
         bus.wr_lo = 1'b1;
         bus.wdata = 32'h1234;
         repeat (3) @(negedge clk);
         checkOutput("lo_hold_busy", 64'(bus.lo), 64'd15);
         bus.wr_lo = 1'b0;
         waitDone("divu_50_5");
      end

      @(negedge clk);
      bus.wr_lo = 1'b1;
      bus.wdata = 32'h1234;
      @(negedge clk);
      bus.wr_lo = 1'b0;
      checkOutput("idle_wr_lo", 64'(bus.lo), 64'h1234);
      checkOutput("idle_wr_lo_hi_kept", 64'(bus.hi), 64'h0);

      bus.wr_hi = 1'b1;
      bus.wr_lo = 1'b1;
      bus.wdata = 32'hABCD;
      @(negedge clk);
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      checkOutput("idle_wr_both_hi", 64'(bus.hi), 64'hABCD);
      checkOutput("idle_wr_both_lo", 64'(bus.lo), 64'hABCD);

      // start and wr_hi together: write dropped, op runs.
      begin
         exp_t e;
         bus.start = 1'b1;
         bus.wr_hi = 1'b1;
         bus.wdata = 32'hDEAD;
         bus.op    = MDU_MULT_U;
         bus.a     = 32'd2;
         bus.b     = 32'd3;
         e = '{name: "start_wr_hi", hi: 32'h0, lo: 32'd6, dbz: 1'b0, lat: LAT_U, start_cyc: cyc};
         sb.push_back(e);
         @(negedge clk);
         bus.start = 1'b0;
         bus.wr_hi = 1'b0;
         checkOutput("start_wr_hi_dropped", 64'(bus.hi), 64'hABCD);
         waitDone("start_wr_hi");
      end

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
